// File: rtl/uart_rx.sv
// UART receiver with a free-running 16x oversample divider and majority-vote bit sampling.
// Delivers one byte per good frame and reports framing/parity errors as one-cycle pulses.
module uart_rx #(
  parameter int unsigned BAUD_DIV   = 27,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_error,
  output logic       rx_parity_error,
  output logic       rx_busy,
  output logic       baud_x16_ce
);

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned TICK_W = 4;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BAUD_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_S7   = TICK_W'(7);
  localparam logic [TICK_W-1:0] TICK_S8   = TICK_W'(8);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(9);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(15);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(7);

  logic                r_sync1, r_sync2;
  logic [DIV_W-1:0]    r_div;
  logic                r_ce;
  logic [2:0]          r_state;
  logic [TICK_W-1:0]   r_tick;
  logic [BIT_W-1:0]    r_bit;
  logic                r_s7, r_s8, r_par;
  logic [DATA_W-1:0]   r_shift, r_data;
  logic                r_valid, r_err, r_perr, r_busy;

  logic [DIV_W-1:0]    w_div;
  logic                w_ce;
  logic [2:0]          w_state;
  logic [TICK_W-1:0]   w_tick;
  logic [BIT_W-1:0]    w_bit;
  logic                w_s7, w_s8, w_par, w_vote, w_rxs;
  logic [DATA_W-1:0]   w_shift, w_data;
  logic                w_valid, w_err, w_perr, w_busy;

  // r_tick holds the index of the upcoming tick, so each tick acts on its own index
  always_comb begin
    w_rxs   = r_sync2;
    w_div   = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    w_ce    = (w_div == DIV_LAST);
    w_vote  = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);
    w_state = r_state;
    w_tick  = r_tick;
    w_bit   = r_bit;
    w_s7    = r_s7;
    w_s8    = r_s8;
    w_par   = r_par;
    w_shift = r_shift;
    w_data  = r_data;
    w_valid = 1'b0;
    w_err   = 1'b0;
    w_perr  = 1'b0;
    if (r_ce) begin
      w_tick = r_tick + TICK_W'(1);
      if (r_tick == TICK_S7) w_s7 = w_rxs;
      if (r_tick == TICK_S8) w_s8 = w_rxs;
      case (r_state)
        S_IDLE: begin
          w_tick = TICK_W'(1);
          if (!w_rxs) w_state = S_START;
        end
        S_START: begin
          if (r_tick == TICK_MID && w_vote) begin
            w_state = S_IDLE;
          end else if (r_tick == TICK_LAST) begin
            w_state = S_DATA;
            w_bit   = '0;
          end
        end
        S_DATA: begin
          if (r_tick == TICK_MID) w_shift[r_bit] = w_vote;
          if (r_tick == TICK_LAST) begin
            if (r_bit == BIT_LAST) w_state = PARITY_EN ? S_PARITY : S_STOP;
            else                   w_bit   = r_bit + BIT_W'(1);
          end
        end
        S_PARITY: begin
          if (r_tick == TICK_MID)  w_par   = w_vote;
          if (r_tick == TICK_LAST) w_state = S_STOP;
        end
        S_STOP: begin
          if (r_tick == TICK_MID) begin
            if (w_vote) begin
              w_data  = r_shift;
              w_valid = 1'b1;
              w_perr  = PARITY_EN && ((^r_shift ^ PARITY_ODD) != r_par);
              w_state = S_IDLE;
            end else begin
              w_err   = 1'b1;
              w_state = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (w_rxs) w_state = S_IDLE;
        end
        default: w_state = S_IDLE;
      endcase
    end
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_div   <= '0;
      r_ce    <= 1'b0;
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_s7    <= 1'b1;
      r_s8    <= 1'b1;
      r_par   <= 1'b0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_perr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_div   <= w_div;
      r_ce    <= w_ce;
      r_state <= w_state;
      r_tick  <= w_tick;
      r_bit   <= w_bit;
      r_s7    <= w_s7;
      r_s8    <= w_s8;
      r_par   <= w_par;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_err   <= w_err;
      r_perr  <= w_perr;
      r_busy  <= w_busy;
    end
  end

  assign rx_data         = r_data;
  assign rx_data_valid   = r_valid;
  assign rx_error        = r_err;
  assign rx_parity_error = r_perr;
  assign rx_busy         = r_busy;
  assign baud_x16_ce     = r_ce;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames built from random bytes, received bytes and pulses
// compared against a frame-level model (byte queue, ones-count parity).
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_p = 1'b1;
  logic [7:0] rx_data, p_data;
  logic       rx_data_valid, rx_error, rx_parity_error, rx_busy, baud_x16_ce;
  logic       p_valid, p_error, p_perr, p_busy, p_ce;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_data[$];
  bit         q_perr[$];
  logic [7:0] qp_data[$];
  bit         qp_perr[$];
  int n_err = 0, np_err = 0, n_overlap = 0, n_stray = 0, busy_cnt = 0;
  logic [7:0] last_byte;

  always #5 clk = ~clk;

  uart_rx #(.BAUD_DIV(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut (
    .clk(clk), .reset(reset), .rx_i(rx), .rx_data(rx_data),
    .rx_data_valid(rx_data_valid), .rx_error(rx_error),
    .rx_parity_error(rx_parity_error), .rx_busy(rx_busy), .baud_x16_ce(baud_x16_ce));

  uart_rx #(.BAUD_DIV(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_par (
    .clk(clk), .reset(reset), .rx_i(rx_p), .rx_data(p_data),
    .rx_data_valid(p_valid), .rx_error(p_error),
    .rx_parity_error(p_perr), .rx_busy(p_busy), .baud_x16_ce(p_ce));

  // Pulse monitor: every received byte and error is logged away from the active edge
  always @(negedge clk) begin
    if (rx_data_valid) begin q_data.push_back(rx_data); q_perr.push_back(rx_parity_error); end
    if (p_valid) begin qp_data.push_back(p_data); qp_perr.push_back(p_perr); end
    if (rx_error) n_err++;
    if (p_error) np_err++;
    if ((rx_data_valid && rx_error) || (p_valid && p_error)) n_overlap++;
    if ((rx_parity_error && !rx_data_valid) || (p_perr && !p_valid)) n_stray++;
    if (rx_busy) busy_cnt++;
  end

  task automatic drive(input bit sel, input bit b, input int n);
    if (sel) rx_p = b; else rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit stop,
                            input bit use_par, input bit pbit);
    drive(sel, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive(sel, d[i], BIT_CLK);
    if (use_par) drive(sel, pbit, BIT_CLK);
    drive(sel, stop, BIT_CLK);
  endtask

  task automatic test_reset();
    int bad = 0, badint = 0, nce = 0, last = -1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_data, rx_data_valid, rx_error, rx_parity_error, rx_busy, baud_x16_ce} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {rx_data, rx_data_valid, rx_error, rx_parity_error, rx_busy, baud_x16_ce});
    end
    reset = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ({rx_data, rx_data_valid, rx_error, rx_parity_error, rx_busy} !== 12'b0) bad++;
      if (baud_x16_ce) begin
        if (last >= 0 && i - last != 4) badint++;
        last = i;
        nce++;
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_quiet got %0d busy/pulse cycles want 0", bad); end
    checks++;
    if (q_data.size() != 0 || n_err != 0) begin
      errors++; $display("FAIL idle_pulses got %0d valid %0d err want 0 0", q_data.size(), n_err);
    end
    checks++;
    if (badint != 0 || nce != 500) begin
      errors++; $display("FAIL ce_period got %0d ticks %0d bad intervals want 500 0", nce, badint);
    end
  endtask

  task automatic test_single();
    int base = q_data.size();
    int ebase = n_err;
    int bbase = busy_cnt;
    send_frame(1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2 * BIT_CLK);
    checks++;
    if (q_data.size() != base + 1) begin
      errors++; $display("FAIL single_count got %0d want 1", q_data.size() - base);
    end else begin
      checks++;
      if (q_data[base] !== 8'h55) begin errors++; $display("FAIL single_data got %h want 55", q_data[base]); end
      last_byte = 8'h55;
    end
    checks++;
    if (n_err != ebase) begin errors++; $display("FAIL single_err got %0d want 0", n_err - ebase); end
    checks++;
    if (busy_cnt - bbase < 600 || busy_cnt - bbase > 625) begin
      errors++; $display("FAIL single_busy got %0d clk want 600..625", busy_cnt - bbase);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    int base = q_data.size();
    int ebase = n_err;
    exp.push_back(8'hA3);
    exp.push_back(8'h0F);
    for (int i = 0; i < 4; i++) exp.push_back(8'($urandom_range(0, 255)));
    foreach (exp[i]) send_frame(1'b0, exp[i], 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2 * BIT_CLK);
    checks++;
    if (q_data.size() - base != exp.size()) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", q_data.size() - base, exp.size());
    end else begin
      foreach (exp[i]) begin
        checks++;
        if (q_data[base + i] !== exp[i]) begin
          errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, q_data[base + i], exp[i]);
        end
      end
      last_byte = exp[exp.size() - 1];
    end
    checks++;
    if (n_err != ebase) begin errors++; $display("FAIL b2b_err got %0d want 0", n_err - ebase); end
  endtask

  task automatic test_false_start();
    int base = q_data.size();
    int ebase = n_err;
    drive(1'b0, 1'b0, 12);
    drive(1'b0, 1'b1, 3 * BIT_CLK);
    checks++;
    if (q_data.size() != base || n_err != ebase || rx_busy !== 1'b0) begin
      errors++; $display("FAIL false_start got valid %0d err %0d busy %b want 0 0 0",
                         q_data.size() - base, n_err - ebase, rx_busy);
    end
    send_frame(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2 * BIT_CLK);
    checks++;
    if (q_data.size() != base + 1 || q_data[q_data.size() - 1] !== 8'h3C) begin
      errors++; $display("FAIL after_false_start got count %0d want 1 byte 3c", q_data.size() - base);
    end else last_byte = 8'h3C;
  endtask

  task automatic test_break();
    int base = q_data.size();
    int ebase = n_err;
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 40 * BIT_CLK);
    checks++;
    if (n_err - ebase != 1 || q_data.size() != base) begin
      errors++; $display("FAIL break_pulses got err %0d valid %0d want 1 0", n_err - ebase, q_data.size() - base);
    end
    checks++;
    if (rx_data !== last_byte || rx_busy !== 1'b1) begin
      errors++; $display("FAIL break_hold got data %h busy %b want %h 1", rx_data, rx_busy, last_byte);
    end
    drive(1'b0, 1'b1, 2 * BIT_CLK);
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_release got busy %b want 0", rx_busy); end
    send_frame(1'b0, 8'h7E, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2 * BIT_CLK);
    checks++;
    if (q_data.size() != base + 1 || q_data[q_data.size() - 1] !== 8'h7E || n_err - ebase != 1) begin
      errors++; $display("FAIL after_break got count %0d err %0d want 1 byte 7e, 1 err",
                         q_data.size() - base, n_err - ebase);
    end else last_byte = 8'h7E;
  endtask

  task automatic test_parity();
    logic [7:0] d[$];
    bit         pb[$];
    int base = qp_data.size();
    d.push_back(8'h07); pb.push_back(1'b0);
    d.push_back(8'h07); pb.push_back(1'b1);
    for (int i = 0; i < 3; i++) begin
      d.push_back(8'($urandom_range(0, 255)));
      pb.push_back(1'($urandom_range(0, 1)));
    end
    foreach (d[i]) send_frame(1'b1, d[i], 1'b1, 1'b1, pb[i]);
    drive(1'b1, 1'b1, 2 * BIT_CLK);
    checks++;
    if (qp_data.size() - base != d.size() || np_err != 0) begin
      errors++; $display("FAIL parity_count got %0d err %0d want %0d 0", qp_data.size() - base, np_err, d.size());
    end else begin
      foreach (d[i]) begin
        // odd parity: data ones plus parity bit must total an odd number
        bit exp_perr = (($countones(d[i]) + int'(pb[i])) % 2) == 0;
        checks++;
        if (qp_data[base + i] !== d[i] || qp_perr[base + i] !== exp_perr) begin
          errors++; $display("FAIL parity[%0d] got %h perr %b want %h perr %b",
                             i, qp_data[base + i], qp_perr[base + i], d[i], exp_perr);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d = 8'($urandom_range(0, 255));
    logic [7:0] d2 = 8'($urandom_range(0, 255));
    int base = q_data.size();
    int ebase = n_err;
    drive(1'b0, 1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive(1'b0, d[i], BIT_CLK);
    drive(1'b0, d[4], BIT_CLK / 2);
    checks++;
    if (rx_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", rx_busy); end
    reset = 1'b1;
    #1;
    checks++;
    if ({rx_data, rx_data_valid, rx_error, rx_parity_error, rx_busy, baud_x16_ce} !== 13'b0) begin
      errors++; $display("FAIL mid_reset_outputs got %h want 0",
                         {rx_data, rx_data_valid, rx_error, rx_parity_error, rx_busy, baud_x16_ce});
    end
    rx = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1, 2 * BIT_CLK);
    checks++;
    if (q_data.size() != base || n_err != ebase) begin
      errors++; $display("FAIL mid_reset_pulses got valid %0d err %0d want 0 0", q_data.size() - base, n_err - ebase);
    end
    send_frame(1'b0, d2, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2 * BIT_CLK);
    checks++;
    if (q_data.size() != base + 1 || q_data[q_data.size() - 1] !== d2) begin
      errors++; $display("FAIL after_reset got count %0d want 1 byte %h", q_data.size() - base, d2);
    end
  endtask

  initial begin
    last_byte = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_break();
    test_parity();
    test_mid_reset();
    checks++;
    if (n_overlap != 0 || n_stray != 0) begin
      errors++; $display("FAIL pulse_exclusive got overlap %0d stray_perr %0d want 0 0", n_overlap, n_stray);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive core with 16x oversampling and a built-in baud-tick divider.
- Converts the asynchronous serial input into parallel bytes plus per-frame status pulses.
- Sits directly upstream of the UART bus wrapper. The wrapper latches rx_data on rx_data_valid and sets its status RX-ready bit from it.
- Runs entirely in the clk_50 domain.

Parameters:
- BAUD_DIV, 27, clk cycles per oversample tick (50 MHz / (16 * 115200), rounded); legal range 1..65535.
- PARITY_EN, 0, 1 = frame carries a parity bit after the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity (ignored when PARITY_EN = 0).

Ports:
- clk  input  1  system clock (clk_50 domain)
- reset  input  1  asynchronous, active-high reset
- rx_i  input  1  serial line; idle high; asynchronous to clk
- rx_data  output  8  last received byte, LSB first on the wire
- rx_data_valid  output  1  one-cycle pulse: frame received with a valid stop bit
- rx_error  output  1  one-cycle pulse: framing error (stop bit sampled 0)
- rx_parity_error  output  1  asserted in the same cycle as rx_data_valid when parity mismatches; otherwise 0
- rx_busy  output  1  high from start-bit detect until return to IDLE
- baud_x16_ce  output  1  one-cycle oversample tick, every BAUD_DIV clocks

Behaviour:
- Reset (asynchronous, active-high):
  - Synchronizer flops are set to 1, so no false start is seen on exit from reset.
  - Divider, tick counter and bit counter clear to 0. FSM goes to IDLE.
  - rx_data = 0x00; rx_data_valid, rx_error, rx_parity_error, rx_busy, baud_x16_ce all = 0.
  - Reset asserted mid-frame abandons the frame. No pulse is emitted.
- Input sync: rx_i passes through a 2-flop synchronizer. All decisions use the synchronized value rxs.
- Divider:
  - Free-running counter from 0 to BAUD_DIV-1.
  - baud_x16_ce pulses on the cycle the counter equals BAUD_DIV-1.
  - The divider is not re-phased on start detect.
- Bit sampling:
  - Each bit spans 16 ticks, indexed 0..15.
  - The bit value is the majority of rxs at ticks 7, 8 and 9.
  - The decision is taken at tick 9.
- FSM states and transitions (all transitions occur on ticks unless stated):
  - IDLE: rx_busy = 0. On rxs = 0 at any tick, go to START with the tick index set to 0.
  - START: at tick 9, if the majority vote is 1, treat it as a false start and return to IDLE (no pulses). Otherwise, at tick 15, go to DATA with bit counter = 0.
  - DATA: store the sampled bit into shift register bit [bit counter] (LSB first). At tick 15, bit counter 7 goes to PARITY if PARITY_EN, else STOP; otherwise increment the bit counter.
  - PARITY: sample the parity bit. Expected value = XOR of the 8 data bits, XOR PARITY_ODD. At tick 15, go to STOP.
  - STOP: at tick 9, decide the stop bit:
    - Stop = 1: on the next clk, rx_data gets the shift register, rx_data_valid = 1 for one cycle, and rx_parity_error = mismatch (one cycle). Then go to IDLE.
    - Stop = 0: rx_error = 1 for one cycle on the next clk. rx_data is not updated. Go to BREAK.
  - BREAK: rx_busy stays 1. Wait for rxs = 1 at a tick, then go to IDLE. This prevents a held-low break from retriggering.
- Back-to-back frames: leaving STOP at tick 9 puts the FSM in IDLE before the next start edge (which arrives at tick 16 or later). No frame is lost at 0% baud error.
- Tolerance: mid-bit sampling gives roughly ±4% combined baud mismatch.
- Pulses are never asserted together: rx_data_valid and rx_error are mutually exclusive. rx_parity_error is only ever high when rx_data_valid is high.
- Latency: rx_data_valid rises 1 clk after the stop-bit tick 9, plus 2 clk of synchronizer delay relative to the pin.

Test Plan (bench uses BAUD_DIV=4, so 64 clk per bit; PARITY_EN=0 unless stated):
- Release reset with rx_i idle high -> all outputs 0 and no pulses for 2000 clk. baud_x16_ce period is exactly 4 clk.
- Send 0x55 with a valid stop bit -> a single rx_data_valid pulse with rx_data=0x55, rx_error=0. rx_busy high for about 9.6 bit times.
- Send 0xA3 then 0x0F back-to-back with no idle gap -> two valid pulses carrying 0xA3 then 0x0F, in order, with no errors.
- Drive rx_i low for 12 clk (3 ticks), then high -> false start: no pulses, FSM back in IDLE. A following 0x3C frame is received correctly.
- Send 0x81 with stop bit 0, then hold the line low for 40 bit times -> exactly one rx_error pulse, rx_data unchanged, no retrigger. After the line goes high, 0x7E is received correctly.
- PARITY_EN=1, PARITY_ODD=1: send 0x07 with parity 0 -> rx_data_valid with rx_parity_error=0. Send 0x07 with parity 1 -> rx_data_valid with rx_parity_error=1.
- Assert reset during data bit 4 of a frame -> no pulses. Outputs return to reset values immediately (asynchronously), and the next full frame is received correctly.
